// File: rtl/gpio_bram_loader.sv
// gpio_bram_loader
//   Loads image pixels into one of three BRAM banks under control of a
//   microcontroller talking over a single GPIO word pair. The micro writes a
//   command word and flips its req bit; the block executes the command and
//   answers by flipping the ack bit in the status word.
//
// Ports
//   CLK100MHZ          single clock
//   i_reset            synchronous active-high reset
//   gpio_o_data_tri_o  command word from the micro
//                        [31] req toggle, [30:29] op (00 WRITE, 01 SETADDR,
//                        10 SETBANK, 11 DONE), low bits carry the argument
//   gpio_i_data_tri_i  status word to the micro
//                        [31] ack, [30] busy, [29] error, [28] wrap,
//                        [27] done, [NB_ADDRESS-1:0] current address
//   o_wrEnable         one-hot write strobe for BRAM banks 0..2
//   o_writeAdd         BRAM write address
//   o_data             BRAM write data (pixel zero-extended)
//   o_done             frame load complete, held until reset
module gpio_bram_loader #(
  parameter int BIT_LEN    = 8,
  parameter int RAM_WIDTH  = 13,
  parameter int NB_ADDRESS = 10,
  parameter int GPIO_D     = 32,
  parameter int DEPTH      = 441
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic [GPIO_D-1:0]     gpio_o_data_tri_o,
  output logic [GPIO_D-1:0]     gpio_i_data_tri_i,
  output logic [2:0]            o_wrEnable,
  output logic [NB_ADDRESS-1:0] o_writeAdd,
  output logic [RAM_WIDTH-1:0]  o_data,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, DECODE, WRITE, ACK} state_t;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_SETADDR = 2'b01;
  localparam logic [1:0] OP_SETBANK = 2'b10;

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(DEPTH - 1);

  function automatic logic [RAM_WIDTH-1:0] zext_pixel(input logic [BIT_LEN-1:0] px);
    zext_pixel = '0;
    zext_pixel[BIT_LEN-1:0] = px;
  endfunction

  state_t                  state;
  logic [GPIO_D-1:0]       cmd_p0;
  logic                    ack;
  logic                    busy;
  logic                    error;
  logic                    wrap;
  logic                    done;
  logic [1:0]              bank;
  logic [NB_ADDRESS-1:0]   addr;

  logic [1:0]              op;
  logic [NB_ADDRESS-1:0]   arg;
  logic                    unused_cmd_bits;

  assign op  = cmd_p0[30:29];
  assign arg = cmd_p0[NB_ADDRESS-1:0];
  assign unused_cmd_bits = ^{cmd_p0[31], cmd_p0[28:NB_ADDRESS]};

  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      // Adopt the micro's current req so releasing reset is not a command.
      ack        <= gpio_o_data_tri_o[31];
      bank       <= 2'd0;
      addr       <= '0;
      error      <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      o_done     <= 1'b0;
      o_wrEnable <= 3'b000;
      o_writeAdd <= '0;
      o_data     <= '0;
    end else begin
      o_wrEnable <= 3'b000;
      case (state)
        // IDLE -> DECODE: the only place the GPIO word is sampled
        IDLE: begin
          if (gpio_o_data_tri_o[31] != ack) begin
            cmd_p0 <= gpio_o_data_tri_o;
            state  <= DECODE;
            busy   <= 1'b1;
          end
        end
        // DECODE -> WRITE / ACK: strobe is registered here so it is high
        // exactly for the WRITE cycle; ack flips on entry to ACK so the
        // micro sees it during the ACK cycle.
        DECODE: begin
          case (op)
            OP_WRITE: begin
              state <= WRITE;
              if (!done) begin
                o_wrEnable <= 3'b001 << bank;
                o_writeAdd <= addr;
                o_data     <= zext_pixel(cmd_p0[BIT_LEN-1:0]);
              end
            end
            OP_SETADDR: begin
              if (arg <= LAST_ADDR) begin
                addr <= arg;
                wrap <= 1'b0;
              end else begin
                error <= 1'b1;
              end
            end
            OP_SETBANK: begin
              if (cmd_p0[1:0] == 2'd3) error <= 1'b1;
              else                     bank  <= cmd_p0[1:0];
            end
            default: begin
              done   <= 1'b1;
              o_done <= 1'b1;
            end
          endcase
          if (op != OP_WRITE) begin
            state <= ACK;
            ack   <= ~ack;
          end
        end
        // WRITE -> ACK: advance address, wrapping at the last image word
        WRITE: begin
          state <= ACK;
          ack   <= ~ack;
          if (!done) begin
            if (addr == LAST_ADDR) begin
              addr <= '0;
              wrap <= 1'b1;
            end else begin
              addr <= addr + NB_ADDRESS'(1);
            end
          end
        end
        // ACK -> IDLE
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    gpio_i_data_tri_i                   = '0;
    gpio_i_data_tri_i[31]               = ack;
    gpio_i_data_tri_i[30]               = busy;
    gpio_i_data_tri_i[29]               = error;
    gpio_i_data_tri_i[28]               = wrap;
    gpio_i_data_tri_i[27]               = done;
    gpio_i_data_tri_i[NB_ADDRESS-1:0]   = addr;
  end

endmodule

// File: tb/tb_gpio_bram_loader.sv
// Directed bench for gpio_bram_loader: drives command words the way the
// micro would and checks status, strobe, address and data cycle by cycle.
module tb_gpio_bram_loader;

  logic        clk;
  logic        rst;
  logic [31:0] gpio;
  logic [31:0] status;
  logic [2:0]  we;
  logic [9:0]  wadd;
  logic [12:0] wdata;
  logic        done_o;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  logic req;

  gpio_bram_loader dut (
    .CLK100MHZ         (clk),
    .i_reset           (rst),
    .gpio_o_data_tri_o (gpio),
    .gpio_i_data_tri_i (status),
    .o_wrEnable        (we),
    .o_writeAdd        (wadd),
    .o_data            (wdata),
    .o_done            (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (we != 3'b000) strobe_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it through to IDLE.
  task automatic do_cmd(input logic [1:0] op, input logic [9:0] arg,
                        input logic [2:0] exp_we, input logic [9:0] exp_add,
                        input logic [12:0] exp_data);
    int   s0;
    logic old_req;
    s0      = strobe_cnt;
    old_req = req;
    req     = ~req;
    gpio    = {req, op, 19'd0, arg};
    step();                                   // N+1: DECODE
    chk("busy_decode", {31'd0, status[30]}, 32'd1);
    chk("ack_hold_n1", {31'd0, status[31]}, {31'd0, old_req});
    step();                                   // N+2
    if (op == 2'b00) begin
      chk("we_n2", {29'd0, we}, {29'd0, exp_we});
      if (exp_we != 3'b000) begin
        chk("waddr_n2", {22'd0, wadd}, {22'd0, exp_add});
        chk("wdata_n2", {19'd0, wdata}, {19'd0, exp_data});
      end
      chk("ack_hold_n2", {31'd0, status[31]}, {31'd0, old_req});
      step();                                 // N+3: ACK
      chk("we_n3", {29'd0, we}, 32'd0);
      chk("ack_n3", {31'd0, status[31]}, {31'd0, req});
    end else begin
      chk("we_ctrl", {29'd0, we}, 32'd0);
      chk("ack_n2", {31'd0, status[31]}, {31'd0, req});
    end
    step();                                   // back in IDLE
    chk("busy_idle", {31'd0, status[30]}, 32'd0);
    chk("strobe_count", strobe_cnt - s0, (exp_we != 3'b000) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic old_req;
    int   s0;

    // Reset with req high, then idle.
    rst  = 1'b1;
    gpio = 32'h8000_0000;
    req  = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_status", status, 32'h8000_0000);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    repeat (5) step();
    chk("idle_status", status, 32'h8000_0000);
    chk("idle_no_strobe", strobe_cnt, 32'd0);

    // SETBANK 1, SETADDR 5, WRITE 0xA7.
    do_cmd(2'b10, 10'd1,   3'b000, 10'd0, 13'h0);
    do_cmd(2'b01, 10'd5,   3'b000, 10'd0, 13'h0);
    chk("addr_after_set", {22'd0, status[9:0]}, 32'd5);
    do_cmd(2'b00, 10'h0A7, 3'b010, 10'd5, 13'h00A7);
    chk("addr_after_wr", {22'd0, status[9:0]}, 32'd6);

    // Wrap at the last address.
    do_cmd(2'b01, 10'd440, 3'b000, 10'd0,   13'h0);
    do_cmd(2'b00, 10'h011, 3'b010, 10'd440, 13'h0011);
    chk("wrap_set", {31'd0, status[28]}, 32'd1);
    chk("addr_wrapped", {22'd0, status[9:0]}, 32'd0);
    do_cmd(2'b00, 10'h022, 3'b010, 10'd0,   13'h0022);
    chk("addr_after_wrap", {22'd0, status[9:0]}, 32'd1);
    chk("wrap_sticky", {31'd0, status[28]}, 32'd1);
    chk("no_err_yet", {31'd0, status[29]}, 32'd0);

    // Invalid SETADDR and SETBANK.
    do_cmd(2'b01, 10'd441, 3'b000, 10'd0, 13'h0);
    chk("err_setaddr", {31'd0, status[29]}, 32'd1);
    chk("addr_kept", {22'd0, status[9:0]}, 32'd1);
    chk("wrap_kept", {31'd0, status[28]}, 32'd1);
    do_cmd(2'b10, 10'd3,   3'b000, 10'd0, 13'h0);
    chk("err_setbank", {31'd0, status[29]}, 32'd1);
    do_cmd(2'b00, 10'h033, 3'b010, 10'd1, 13'h0033);   // bank still 1
    do_cmd(2'b01, 10'd0,   3'b000, 10'd0, 13'h0);
    chk("wrap_cleared", {31'd0, status[28]}, 32'd0);
    chk("err_sticky", {31'd0, status[29]}, 32'd1);
    chk("addr_zero", {22'd0, status[9:0]}, 32'd0);

    // DONE, then a WRITE that must not strobe.
    do_cmd(2'b11, 10'd0,   3'b000, 10'd0, 13'h0);
    chk("o_done", {31'd0, done_o}, 32'd1);
    chk("status_done", {31'd0, status[27]}, 32'd1);
    do_cmd(2'b00, 10'h055, 3'b000, 10'd0, 13'h0);
    chk("done_held", {31'd0, done_o}, 32'd1);
    chk("addr_frozen", {22'd0, status[9:0]}, 32'd0);

    // Reset clears flags and takes ack from the current req.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset2_status", status, {req, 31'd0});
    chk("reset2_done", {31'd0, done_o}, 32'd0);

    // WRITE aborted by reset at the edge that would raise the strobe.
    s0      = strobe_cnt;
    old_req = req;
    req     = ~req;
    gpio    = {req, 2'b00, 19'd0, 10'h066};
    step();                                   // N+1: DECODE
    chk("abort_busy", {31'd0, status[30]}, 32'd1);
    chk("abort_ack_hold", {31'd0, status[31]}, {31'd0, old_req});
    rst = 1'b1;
    step();                                   // N+2 under reset
    chk("abort_we", {29'd0, we}, 32'd0);
    chk("abort_ack", {31'd0, status[31]}, {31'd0, req});
    chk("abort_idle", {31'd0, status[30]}, 32'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("abort_quiet_busy", {31'd0, status[30]}, 32'd0);
    chk("abort_quiet_ack", {31'd0, status[31]}, {31'd0, req});
    chk("abort_no_strobe", strobe_cnt - s0, 32'd0);

    // Bank is back to 0 after reset.
    do_cmd(2'b00, 10'h066, 3'b001, 10'd0, 13'h0066);
    chk("addr_after_reset_wr", {22'd0, status[9:0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_bram_loader.md
GPIO_BRAM_LOADER -- requirements
Module: gpio_bram_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BIT_LEN, 8, pixel width.
- RAM_WIDTH, 13, BRAM word width.
- NB_ADDRESS, 10, BRAM address width.
- GPIO_D, 32, GPIO word width.
- DEPTH, 441, number of valid image addresses per bank.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK100MHZ, in, 1, the single clock.
- i_reset, in, 1, synchronous active-high reset.
- gpio_o_data_tri_o, in, GPIO_D, command word from the micro.
- gpio_i_data_tri_i, out, GPIO_D, status word to the micro.
- o_wrEnable, out, 3, one-hot write strobe for BRAM banks 0..2.
- o_writeAdd, out, NB_ADDRESS, BRAM write address.
- o_data, out, RAM_WIDTH, BRAM write data.
- o_done, out, 1, frame load complete.
REQ-003 Command word fields SHALL be:
- [31]: req toggle.
- [30:29]: op; 00 WRITE, 01 SETADDR, 10 SETBANK, 11 DONE.
- [BIT_LEN-1:0]: WRITE pixel.
- [NB_ADDRESS-1:0]: SETADDR address.
- [1:0]: SETBANK bank.
REQ-004 Status word fields SHALL be:
- [31]: ack toggle.
- [30]: busy.
- [29]: error.
- [28]: wrap.
- [27]: done.
- [NB_ADDRESS-1:0]: current address.
- All other bits: 0.

Function
REQ-005 A new command SHALL be detected when the block is in IDLE and gpio[31] differs from the ack bit.
REQ-006 The state machine SHALL have four states with these transitions:
- IDLE -> DECODE on a detected command; the full command word is latched in that cycle.
- DECODE -> WRITE when op=WRITE.
- DECODE -> ACK for any other op.
- WRITE -> ACK unconditionally.
- ACK -> IDLE unconditionally.
REQ-007 busy SHALL be 1 in DECODE, WRITE and ACK, and 0 in IDLE.
REQ-008 The ACK state SHALL invert the ack bit, so ack changes exactly once per command.
REQ-009 Cycle timing for a command detected in cycle N SHALL be:
- WRITE: o_wrEnable is high during cycle N+2 only; ack is visible toggled from cycle N+3.
- Non-WRITE: ack is visible toggled from cycle N+2.
REQ-010 WRITE SHALL drive the following in the WRITE cycle:
- o_wrEnable[bank]=1.
- o_writeAdd = current address.
- o_data = pixel zero-extended to RAM_WIDTH.
REQ-011 o_wrEnable SHALL be 3'b000 in every cycle other than WRITE.
REQ-012 After a WRITE the address SHALL increment by 1.
REQ-013 A WRITE at address DEPTH-1 SHALL complete, then set the address to 0 and set wrap=1.
REQ-014 SETADDR with value < DEPTH SHALL load the address and clear wrap.
REQ-015 SETADDR with value >= DEPTH SHALL set error=1 and leave the address unchanged.
REQ-016 SETBANK with value 0..2 SHALL select that bank.
REQ-017 SETBANK with value 3 SHALL set error=1 and leave the bank unchanged.
REQ-018 DONE SHALL set done=1 and o_done=1, both held until reset.
REQ-019 When done=1, WRITE SHALL be acknowledged without any write strobe.
REQ-020 error and wrap SHALL be sticky; only reset or a valid SETADDR clears wrap, and only reset clears error.
REQ-021 gpio changes while busy SHALL be ignored; the word is latched only in IDLE.
REQ-022 A req toggle-back received during busy SHALL be evaluated on return to IDLE against the updated ack.
REQ-023 All outputs SHALL be registered; no combinational path SHALL exist from gpio_o_data_tri_o to any output.

Reset
REQ-024 When i_reset=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear bank, address, error, wrap, done and o_done;
- drive o_wrEnable=0, o_writeAdd=0, o_data=0;
- load ack with the current gpio[31], so no spurious command follows reset release.
REQ-025 Reset SHALL override all states; a reset in the WRITE cycle suppresses that strobe, and an in-flight command is discarded without ack.

Verification
REQ-026 The bench SHALL cover the following scenarios:
- Reset with gpio[31]=1, then 5 idle cycles -> ack=1, busy=0, o_wrEnable never asserted.
- SETBANK 1, SETADDR 5, WRITE 0xA7 -> o_wrEnable=3'b010, o_writeAdd=5, o_data=13'h00A7 for exactly 1 cycle, ack at N+3, status address=6.
- SETADDR 440, WRITE 0x11, WRITE 0x22 -> writes at 440 then 0, wrap=1, final status address=1.
- SETADDR 441, then SETBANK 3 -> error=1, address and bank unchanged, each ack at N+2.
- DONE, then WRITE 0x55 -> o_done=1, ack toggles, no write strobe.
- WRITE issued, i_reset asserted in cycle N+2 -> no strobe, ack equals the gpio[31] sampled at the reset edge, state IDLE.
